// File: rtl/noisy_denoise_if.sv
// Sample-stream bus between the noisy source and the denoise stage.
// The source drives the sample, qualifiers and controls; the
// denoiser returns the filtered sample and its priming status.
interface noisy_denoise_if #(
  parameter int W = 14
);
  logic                in_valid;
  logic signed [W-1:0] sigin;
  logic                bypass;
  logic                clear;
  logic                out_valid;
  logic signed [W-1:0] sigout;
  logic                primed;

  modport master (
    output in_valid, sigin, bypass, clear,
    input  out_valid, sigout, primed
  );

  modport slave (
    input  in_valid, sigin, bypass, clear,
    output out_valid, sigout, primed
  );
endinterface

// File: rtl/noisy_denoise.sv
// Boxcar moving-average denoiser over 2^LOG2_LEN samples.
// A circular window and a running sum are kept, so each accepted
// sample costs one add and one subtract. The output is registered,
// which gives one clock of latency. During warm-up the empty slots
// count as zero, so the output ramps up until the window is primed.
module noisy_denoise #(
  parameter int LOG2_LEN = 3,
  parameter int W        = 14
) (
  input  logic           clk,
  input  logic           rst,
  noisy_denoise_if.slave bus
);

  localparam int N      = 1 << LOG2_LEN;
  localparam int SW     = W + LOG2_LEN;
  localparam int HALF_I = 1 << (LOG2_LEN - 1);

  localparam logic signed [SW:0]     MAX_S = (SW+1)'((2 ** (W - 1)) - 1);
  localparam logic signed [SW:0]     MIN_S = ~MAX_S;
  localparam logic signed [SW:0]     HALF  = (SW+1)'(HALF_I);
  localparam logic [LOG2_LEN:0]      FULL  = (LOG2_LEN+1)'(N);

  logic signed [W-1:0]     window_q [N];
  logic signed [SW-1:0]    sum_q;
  logic [LOG2_LEN-1:0]     ptr_q;
  logic [LOG2_LEN:0]       fill_q;
  logic                    out_valid_q;
  logic signed [W-1:0]     sigout_q;
  logic                    primed_q;

  logic signed [SW-1:0]    sigin_ext;
  logic signed [SW-1:0]    oldest_ext;
  logic signed [SW-1:0]    sum_next;
  logic signed [SW:0]      rounded_sum;
  logic signed [SW:0]      avg_wide;
  logic signed [W-1:0]     avg_sat;
  logic [LOG2_LEN:0]       fill_plus;

  // Next running sum, rounded average and saturated result for the incoming sample
  always_comb begin
    sigin_ext   = $signed({{LOG2_LEN{bus.sigin[W-1]}}, bus.sigin});
    oldest_ext  = $signed({{LOG2_LEN{window_q[ptr_q][W-1]}}, window_q[ptr_q]});
    sum_next    = sum_q + sigin_ext - oldest_ext;
    rounded_sum = $signed({sum_next[SW-1], sum_next}) + HALF;
    avg_wide    = rounded_sum >>> LOG2_LEN;
    fill_plus   = fill_q + 1'b1;
    if (avg_wide > MAX_S) begin
      avg_sat = MAX_S[W-1:0];
    end else if (avg_wide < MIN_S) begin
      avg_sat = MIN_S[W-1:0];
    end else begin
      avg_sat = avg_wide[W-1:0];
    end
  end

  // Window, running sum, fill tracking and registered output; reset beats clear beats a sample
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        window_q[i] <= '0;
      end
      sum_q       <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sigout_q    <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < N; i++) begin
        window_q[i] <= '0;
      end
      sum_q       <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      window_q[ptr_q] <= bus.sigin;
      sum_q           <= sum_next;
      ptr_q           <= ptr_q + 1'b1;
      fill_q          <= (fill_q >= FULL) ? FULL : fill_plus;
      primed_q        <= (fill_plus >= FULL);
      out_valid_q     <= 1'b1;
      sigout_q        <= bus.bypass ? bus.sigin : avg_sat;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sigout    = sigout_q;
  assign bus.primed    = primed_q;

endmodule

// File: tb/tb_noisy_denoise.sv
// Directed bench for the moving-average denoiser (N = 8, W = 14).
// Expected values are hand-computed from the rounding rule
// (sum + 4) >>> 3 and written as constants below.
module tb_noisy_denoise;

  logic clk;
  logic rst;
  int   check_count;
  int   pass_count;

  noisy_denoise_if #(.W(14)) bus ();

  noisy_denoise #(.LOG2_LEN(3), .W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and count the result
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle 1 ns past the edge
  task automatic applyStimulus(input logic valid, input int sample,
                               input logic byp, input logic clr);
    bus.in_valid = valid;
    bus.sigin    = 14'(sample);
    bus.bypass   = byp;
    bus.clear    = clr;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two cycles, then release with inputs idle
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    int ramp [10];
    ramp = '{100, 200, 300, 400, 500, 600, 700, 800, 800, 800};
    check_count  = 0;
    pass_count   = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.sigin    = '0;
    bus.bypass   = 1'b0;
    bus.clear    = 1'b0;

    // Reset state
    doReset();
    checkOutput("reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("reset_sigout", int'(bus.sigout), 0);
    checkOutput("reset_primed", int'(bus.primed), 0);

    // Constant 800 ramps up then holds; primed rises with the 8th output
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 800, 1'b0, 1'b0);
      checkOutput($sformatf("ramp_valid_%0d", k), int'(bus.out_valid), 1);
      checkOutput($sformatf("ramp_sigout_%0d", k), int'(bus.sigout), ramp[k]);
      checkOutput($sformatf("ramp_primed_%0d", k), int'(bus.primed), (k >= 7) ? 1 : 0);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("ramp_valid_drop", int'(bus.out_valid), 0);
    checkOutput("ramp_hold", int'(bus.sigout), 800);

    // Rounding and sign of small negatives
    doReset();
    applyStimulus(1'b1, -3, 1'b0, 1'b0);
    checkOutput("neg3_sigout", int'(bus.sigout), 0);
    doReset();
    applyStimulus(1'b1, -5, 1'b0, 1'b0);
    checkOutput("neg5_sigout", int'(bus.sigout), -1);

    // Positive extreme
    doReset();
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 8191, 1'b0, 1'b0);
    checkOutput("max_sigout", int'(bus.sigout), 8191);

    // Negative extreme
    doReset();
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, -8192, 1'b0, 1'b0);
    checkOutput("min_sigout", int'(bus.sigout), -8192);

    // Gapped input: out_valid only after valid cycles, sigout holds in gaps
    doReset();
    applyStimulus(1'b1, 800, 1'b0, 1'b0);
    checkOutput("gap_valid_1", int'(bus.out_valid), 1);
    checkOutput("gap_sigout_1", int'(bus.sigout), 100);
    applyStimulus(1'b0, 800, 1'b0, 1'b0);
    checkOutput("gap_valid_2", int'(bus.out_valid), 0);
    checkOutput("gap_hold_2", int'(bus.sigout), 100);
    applyStimulus(1'b1, 800, 1'b0, 1'b0);
    checkOutput("gap_valid_3", int'(bus.out_valid), 1);
    checkOutput("gap_sigout_3", int'(bus.sigout), 200);
    applyStimulus(1'b0, 800, 1'b0, 1'b0);
    checkOutput("gap_valid_4", int'(bus.out_valid), 0);
    checkOutput("gap_hold_4", int'(bus.sigout), 200);

    // Bypass passes samples through while the window keeps updating
    doReset();
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    checkOutput("byp_5", int'(bus.sigout), 5);
    applyStimulus(1'b1, -7, 1'b1, 1'b0);
    checkOutput("byp_neg7", int'(bus.sigout), -7);
    applyStimulus(1'b1, 1000, 1'b1, 1'b0);
    checkOutput("byp_1000", int'(bus.sigout), 1000);
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    checkOutput("byp_release_avg", int'(bus.sigout), 125);

    // Clear drops the coincident sample and empties the window
    doReset();
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 800, 1'b0, 1'b0);
    checkOutput("clr_pre_primed", int'(bus.primed), 1);
    applyStimulus(1'b1, 400, 1'b0, 1'b1);
    checkOutput("clr_valid", int'(bus.out_valid), 0);
    checkOutput("clr_primed", int'(bus.primed), 0);
    checkOutput("clr_sigout_hold", int'(bus.sigout), 800);
    applyStimulus(1'b1, 400, 1'b0, 1'b0);
    checkOutput("clr_next_valid", int'(bus.out_valid), 1);
    checkOutput("clr_next_sigout", int'(bus.sigout), 50);

    // Mid-stream reset returns everything to the reset state
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 800, 1'b0, 1'b0);
    checkOutput("rst_pre_primed", int'(bus.primed), 1);
    rst = 1'b1;
    applyStimulus(1'b1, 400, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_valid", int'(bus.out_valid), 0);
    checkOutput("rst_sigout", int'(bus.sigout), 0);
    checkOutput("rst_primed", int'(bus.primed), 0);
    applyStimulus(1'b1, 400, 1'b0, 1'b0);
    checkOutput("rst_next_sigout", int'(bus.sigout), 50);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
